multi_chan_countdown_timer: RTL and testbench

- Parametrised multi-channel down-counter/timer block. Each channel takes a load value, counts down on a shared prescaled tick, and raises a sticky expiry flag.
- Channels run one-shot or auto-reload (periodic). Counters are readable live; a combined interrupt line feeds the host interface.
- Replaces single-channel load/count-down counters in the FPGA interface layer.

---
 rtl/multi_chan_countdown_timer_if.sv | 27 ++
 rtl/multi_chan_countdown_timer.sv | 71 +++++++
 tb/tb_multi_chan_countdown_timer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/multi_chan_countdown_timer_if.sv
// multi_chan_countdown_timer_if: host-side configuration and status bundle for the countdown timer block
interface multi_chan_countdown_timer_if #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int PRE_W = 8,
  parameter int CH_W  = 2
);
  logic                 cfg_we;
  logic [CH_W-1:0]      cfg_ch;
  logic [WIDTH-1:0]     cfg_load;
  logic                 cfg_periodic;
  logic                 cfg_enable;
  logic [PRE_W-1:0]     prescale;
  logic [NCH-1:0]       irq_clr;
  logic [NCH*WIDTH-1:0] count_flat;
  logic [NCH-1:0]       busy;
  logic [NCH-1:0]       expired;
  logic                 irq;
  modport master (
    output cfg_we, cfg_ch, cfg_load, cfg_periodic, cfg_enable, prescale, irq_clr,
    input  count_flat, busy, expired, irq
  );
  modport slave (
    input  cfg_we, cfg_ch, cfg_load, cfg_periodic, cfg_enable, prescale, irq_clr,
    output count_flat, busy, expired, irq
  );
endinterface

// File: rtl/multi_chan_countdown_timer.sv
// multi_chan_countdown_timer: NCH down-counters on a shared prescaled tick, one-shot or auto-reload, sticky expiry flags
module multi_chan_countdown_timer #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int PRE_W = 8,
  parameter int CH_W  = 2
) (
  input logic clk,
  input logic nreset,
  multi_chan_countdown_timer_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_t;
  logic [PRE_W-1:0] pre_cnt;
  logic tick;
  logic [NCH-1:0] busy_v, exp_v;
  logic [NCH-1:0][WIDTH-1:0] cnt_v;
  // >= rather than == so lowering prescale mid-period ticks at once instead of wrapping
  assign tick = pre_cnt >= bus.prescale;
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) pre_cnt <= '0;
    else pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    state_t state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d, reload_q, reload_d;
    logic per_q, per_d, exp_q, exp_d, sel;
    assign sel = bus.cfg_we && bus.cfg_ch == CH_W'(i);
    always_ff @(posedge clk or negedge nreset)
      if (!nreset) begin
        state_q  <= IDLE;
        count_q  <= '0;
        reload_q <= '0;
        per_q    <= 1'b0;
        exp_q    <= 1'b0;
      end else begin
        state_q  <= state_d;
        count_q  <= count_d;
        reload_q <= reload_d;
        per_q    <= per_d;
        exp_q    <= exp_d;
      end
    // clear applied first so any set below wins on the same edge
    always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      per_d    = per_q;
      exp_d    = exp_q & ~bus.irq_clr[i];
      if (sel) begin
        count_d  = bus.cfg_load;
        reload_d = bus.cfg_load;
        per_d    = bus.cfg_periodic;
        state_d  = (bus.cfg_enable && bus.cfg_load != '0) ? RUN : IDLE;
        if (bus.cfg_enable && bus.cfg_load == '0) exp_d = 1'b1;
      end else if (state_q == RUN && tick) begin
        if (count_q > WIDTH'(1)) count_d = count_q - WIDTH'(1);
        else begin
          exp_d   = 1'b1;
          count_d = per_q ? reload_q : '0;
          state_d = per_q ? RUN : IDLE;
        end
      end
    end
    assign busy_v[i] = state_q == RUN;
    assign exp_v[i]  = exp_q;
    assign cnt_v[i]  = count_q;
  end
  assign bus.count_flat = cnt_v;
  assign bus.busy       = busy_v;
  assign bus.expired    = exp_v;
  assign bus.irq        = |exp_v;
endmodule

// File: tb/tb_multi_chan_countdown_timer.sv
// tb_multi_chan_countdown_timer: directed checks of the countdown timer with hand-computed expectations
module tb_multi_chan_countdown_timer;
  localparam int W = 16;
  logic clk = 1'b0;
  logic nreset = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  multi_chan_countdown_timer_if #(.WIDTH(W), .NCH(4), .PRE_W(8), .CH_W(2)) b ();
  multi_chan_countdown_timer_if #(.WIDTH(W), .NCH(3), .PRE_W(8), .CH_W(2)) b3 ();
  multi_chan_countdown_timer #(.WIDTH(W), .NCH(4), .PRE_W(8), .CH_W(2)) dut (.clk(clk), .nreset(nreset), .bus(b));
  multi_chan_countdown_timer #(.WIDTH(W), .NCH(3), .PRE_W(8), .CH_W(2)) dut3 (.clk(clk), .nreset(nreset), .bus(b3));
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [W-1:0] cnt(input int i);
    return b.count_flat[i*W +: W];
  endfunction
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wr(input int ch, input int load, input logic per, input logic en);
    b.cfg_we = 1'b1;
    b.cfg_ch = 2'(ch);
    b.cfg_load = W'(load);
    b.cfg_periodic = per;
    b.cfg_enable = en;
    step(1);
    b.cfg_we = 1'b0;
  endtask
  initial begin
    {b.cfg_we, b.cfg_ch, b.cfg_load, b.cfg_periodic, b.cfg_enable, b.prescale, b.irq_clr} = '0;
    {b3.cfg_we, b3.cfg_ch, b3.cfg_load, b3.cfg_periodic, b3.cfg_enable, b3.prescale, b3.irq_clr} = '0;
    step(2);
    check("reset_count", b.count_flat, 0);
    check("reset_busy", b.busy, 0);
    check("reset_irq", b.irq, 0);
    nreset = 1'b1;
    // reset in the middle of a run, observed without any clock edge
    wr(0, 100, 0, 1);
    step(10);
    check("run_ch0_90", cnt(0), 90);
    nreset = 1'b0;
    #2;
    check("async_count", b.count_flat, 0);
    check("async_busy", b.busy, 0);
    check("async_exp", b.expired, 0);
    check("async_irq", b.irq, 0);
    nreset = 1'b1;
    // one-shot, tick every cycle
    wr(1, 5, 0, 1);
    check("os_load", cnt(1), 5);
    check("os_busy0", b.busy[1], 1);
    for (int k = 1; k <= 4; k++) begin
      step(1);
      check("os_count", cnt(1), 64'(5 - k));
      check("os_noexp", b.expired[1], 0);
    end
    step(1);
    check("os_zero", cnt(1), 0);
    check("os_exp", b.expired[1], 1);
    check("os_busy_fall", b.busy[1], 0);
    check("os_irq", b.irq, 1);
    step(3);
    check("os_hold0", cnt(1), 0);
    b.irq_clr = 4'b0010;
    step(1);
    b.irq_clr = '0;
    check("os_clr", b.expired[1], 0);
    check("os_irq_clr", b.irq, 0);
    // periodic with P=3; reset aligns the prescaler so ticks land on edges 4, 8, 12, ...
    b.prescale = 8'd3;
    nreset = 1'b0;
    #1;
    nreset = 1'b1;
    wr(2, 3, 1, 1);
    check("per_load", cnt(2), 3);
    step(2);
    check("per_e3", cnt(2), 3);
    step(1);
    check("per_e4", cnt(2), 2);
    step(3);
    check("per_e7", cnt(2), 2);
    step(1);
    check("per_e8", cnt(2), 1);
    step(3);
    check("per_e11_noexp", b.expired[2], 0);
    step(1);
    check("per_e12_reload", cnt(2), 3);
    check("per_e12_exp", b.expired[2], 1);
    check("per_e12_busy", b.busy[2], 1);
    b.irq_clr = 4'b0100;
    step(1);
    b.irq_clr = '0;
    check("per_clr", b.expired[2], 0);
    step(10);
    check("per_e23", cnt(2), 1);
    check("per_e23_noexp", b.expired[2], 0);
    step(1);
    check("per_e24_exp", b.expired[2], 1);
    check("per_e24_reload", cnt(2), 3);
    // stop a running channel with an enable=0 write
    b.prescale = 8'd0;
    wr(2, 7, 0, 0);
    check("stop_busy", b.busy[2], 0);
    check("stop_count", cnt(2), 7);
    step(3);
    check("stop_hold", cnt(2), 7);
    b.irq_clr = 4'b0100;
    step(1);
    b.irq_clr = '0;
    check("stop_clr", b.expired, 0);
    // clear and expiry on the same edge: set wins
    wr(0, 2, 0, 1);
    step(1);
    check("sim_c0_1", cnt(0), 1);
    b.irq_clr = 4'b0001;
    step(1);
    b.irq_clr = '0;
    check("sim_set_wins", b.expired[0], 1);
    check("sim_c0_0", cnt(0), 0);
    // write on a tick edge loads exactly; other channels keep counting
    wr(1, 10, 0, 1);
    wr(3, 20, 0, 1);
    check("tickwr_c3", cnt(3), 20);
    check("tickwr_c1", cnt(1), 9);
    step(1);
    check("tickwr_c3_next", cnt(3), 19);
    check("tickwr_c1_next", cnt(1), 8);
    // zero load with enable: immediate expiry, stays idle
    b.irq_clr = 4'b0001;
    step(1);
    b.irq_clr = '0;
    check("z_pre", b.expired[0], 0);
    wr(0, 0, 0, 1);
    check("z_exp", b.expired[0], 1);
    check("z_busy", b.busy[0], 0);
    check("z_count", cnt(0), 0);
    // out-of-range channel on a 3-channel instance
    b3.cfg_we = 1'b1; b3.cfg_ch = 2'd1; b3.cfg_load = 16'd50; b3.cfg_enable = 1'b0;
    step(1);
    b3.cfg_ch = 2'd3; b3.cfg_load = 16'd99; b3.cfg_enable = 1'b1;
    step(1);
    b3.cfg_we = 1'b0;
    step(1);
    check("oor_count", b3.count_flat, 64'(48'd50 << 16));
    check("oor_busy", b3.busy, 0);
    check("oor_exp", b3.expired, 0);
    // prescale lowered below pre_cnt
    b.prescale = 8'd200;
    nreset = 1'b0;
    #1;
    nreset = 1'b1;
    wr(1, 3, 0, 1);
    wr(2, 5, 1, 1);
    step(148);
    check("pc_e150_c1", cnt(1), 3);
    check("pc_e150_c2", cnt(2), 5);
    b.prescale = 8'd10;
    step(1);
    check("pc_e151_c1", cnt(1), 2);
    check("pc_e151_c2", cnt(2), 4);
    step(10);
    check("pc_e161_c1", cnt(1), 2);
    step(1);
    check("pc_e162_c1", cnt(1), 1);
    check("pc_e162_c2", cnt(2), 3);
    step(11);
    check("pc_e173_c1", cnt(1), 0);
    check("pc_e173_exp", b.expired, 4'b0010);
    check("pc_e173_c2", cnt(2), 2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
